sound_voices: RTL and testbench
===============================

// Module: sound_voices
// PURPOSE
//   Polyphonic successor to the single-voice game sound generator. Accepts triggered sound
//   commands (mode, pitch, length, priority) and allocates each one to one of NUM_VOICES
//   square-wave voices, stealing a lower-priority voice when all are busy. Voice outputs are
//   summed into a level and then converted to a 1-bit audio pin by a first-order sigma-delta
//   modulator. Sits between the game logic (event sources) and the audio output pin.
// PARAMETERS
//   NUM_VOICES  2  number of simultaneous voices (>=1)
//   DIV_WIDTH   4  pitch divider width; half-period = pitch+1 pwm_base edges
//   LEN_WIDTH   5  sound length / phase counter width, counted in frames
// PORTS
//   clk          in   1                  system clock
//   rst          in   1                  synchronous reset, active-high
//   vsync        in   1                  frame strobe; rising edge = frame tick
//   pwm_base     in   1                  tone timebase; rising edge = tone tick
//   trig         in   1                  single-cycle sound request
//   trig_mode    in   2                  0 none(ignored), 1 BLIP, 2 SWEEP, 3 WARBLE
//   trig_pitch   in   DIV_WIDTH          initial divider value
//   trig_len     in   LEN_WIDTH          duration in frames (0 treated as 1)
//   trig_prio    in   2                  priority, 3 highest
//   voice_busy   out  NUM_VOICES         voice i active
//   trig_drop    out  1                  pulse: request rejected, no voice available
//   audio_level  out  $clog2(NUM_VOICES+1)  count of active voices whose square output is high
//   audio        out  1                  sigma-delta modulated audio
// BEHAVIOUR
//   - Edge detect: prev_vsync and prev_pwm_base reset to 1, so an input held high
//     across reset release produces no edge. Ticks are the rising edges of these inputs.
//   - Reset: all voices idle. pitch, phase, div counters and square outputs are 0.
//     audio, audio_level, trig_drop, voice_busy and the sigma-delta accumulator are 0.
//     A reset mid-sound silences everything on the next edge.
//   - Allocation: uses registered state only. trig with trig_mode==0 is ignored.
//     1) Pick the lowest-index idle voice.
//     2) Otherwise pick the busy voice with the lowest prio strictly below trig_prio
//        (lowest index on ties) and restart it.
//     3) Otherwise drop: trig_drop=1 the next cycle for exactly 1 cycle.
//   - Latency: voice_busy rises 1 cycle after trig.
//   - Voice start: the voice loads mode, pitch, len and prio. phase=0, div=0, square=0.
//   - A voice ending on the same cycle as a trig still counts as busy for that trig.
//   - Tone: on each tone tick an active voice does div = (div==pitch) ? 0 : div+1.
//     It toggles square whenever div wraps, i.e. half-period = pitch+1 tone ticks.
//   - Frame: on each frame tick an active voice does phase++.
//     - The voice goes idle when the incremented phase reaches max(len,1).
//     - A voice started on a cycle that also carries a frame tick ignores that tick.
//   - SWEEP: on each frame tick pitch+1 while phase < len/2, else pitch-1.
//     Pitch saturates at 0 and at 2^DIV_WIDTH-1; it never wraps.
//   - WARBLE: square contribution is masked while phase[2]==1 (its div still runs).
//   - BLIP: fixed pitch.
//   - audio_level: registered popcount of (busy & square & ~mask). Idle voices contribute 0.
//   - Sigma-delta: every clk, s = acc + audio_level.
//     If s >= NUM_VOICES then audio<=1 and acc<=s-NUM_VOICES, else audio<=0 and acc<=s.
//     The 1-density of audio equals audio_level/NUM_VOICES.
// TESTING
//   1. Reset released with vsync=pwm_base=1 -> no tick is counted; all outputs stay 0.
//   2. BLIP pitch=3 len=4 on voice 0, pwm_base period 4 clk -> square toggles every
//      16 clk; voice_busy[0] drops on the 4th vsync rising edge.
//   3. Two trigs with prio 1, then a third with prio 2 (NUM_VOICES=2) -> voice 0 is
//      restarted; a fourth trig with prio 0 -> trig_drop pulses 1 cycle.
//   4. SWEEP pitch=14 len=8 -> pitch 15,15,15,15 (saturates), then 14,13,12,11; voice
//      then goes idle.
//   5. WARBLE len=12 -> audio_level is 0 for frames 4-7 even while div toggles.
//   6. Both voices high with NUM_VOICES=2 -> audio constant 1; one high -> audio alternates 1,0.

Source files
------------

// File: rtl/sound_voices.sv
// Polyphonic square-wave sound generator: voice allocation with priority
// stealing, per-voice tone/frame sequencing, level summation and a
// first-order sigma-delta modulator driving a 1-bit audio pin.

module sound_voice #(
   parameter int DIV_WIDTH = 4,
   parameter int LEN_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 frame_tick,
   input  logic                 tone_tick,
   input  logic [1:0]           start_mode,
   input  logic [DIV_WIDTH-1:0] start_pitch,
   input  logic [LEN_WIDTH-1:0] start_len,
   input  logic [1:0]           start_prio,
   output logic                 busy,
   output logic [1:0]           prio,
   output logic [DIV_WIDTH-1:0] pitch,
   output logic                 level_bit
);
   localparam logic [1:0] M_SWEEP  = 2'd2;
   localparam logic [1:0] M_WARBLE = 2'd3;

   logic [1:0]           mode;
   logic [LEN_WIDTH-1:0] len, len_eff, phase, phase_nxt;
   logic [DIV_WIDTH-1:0] div;
   logic                 square;

   assign len_eff   = (len == '0) ? LEN_WIDTH'(1) : len;
   assign phase_nxt = phase + LEN_WIDTH'(1);
   // WARBLE silences the output in alternate 4-frame windows; div keeps running
   assign level_bit = busy & square & ~((mode == M_WARBLE) & phase[2]);

   // voice state: a start overrides any tick arriving on the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         mode   <= '0;
         prio   <= '0;
         pitch  <= '0;
         len    <= '0;
         phase  <= '0;
         div    <= '0;
         square <= 1'b0;
      end else if (start) begin
         busy   <= 1'b1;
         mode   <= start_mode;
         prio   <= start_prio;
         pitch  <= start_pitch;
         len    <= start_len;
         phase  <= '0;
         div    <= '0;
         square <= 1'b0;
      end else if (busy) begin
         if (tone_tick) begin
            if (div == pitch) begin
               div    <= '0;
               square <= ~square;
            end else begin
               div <= div + DIV_WIDTH'(1);
            end
         end
         if (frame_tick) begin
            phase <= phase_nxt;
            if (phase_nxt >= len_eff) busy <= 1'b0;
            if (mode == M_SWEEP) begin
               if (phase < (len >> 1)) begin
                  if (pitch != '1) pitch <= pitch + DIV_WIDTH'(1);
               end else begin
                  if (pitch != '0) pitch <= pitch - DIV_WIDTH'(1);
               end
            end
         end
      end
   end
endmodule

module sound_voices #(
   parameter int NUM_VOICES = 2,
   parameter int DIV_WIDTH  = 4,
   parameter int LEN_WIDTH  = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              vsync,
   input  logic                              pwm_base,
   input  logic                              trig,
   input  logic [1:0]                        trig_mode,
   input  logic [DIV_WIDTH-1:0]              trig_pitch,
   input  logic [LEN_WIDTH-1:0]              trig_len,
   input  logic [1:0]                        trig_prio,
   output logic [NUM_VOICES-1:0]             voice_busy,
   output logic                              trig_drop,
   output logic [$clog2(NUM_VOICES+1)-1:0]   audio_level,
   output logic                              audio
);
   localparam int AW = $clog2(NUM_VOICES+1);
   localparam int SW = AW + 1;

   logic prev_vsync, prev_pwm_base;
   logic frame_tick, tone_tick;
   logic [NUM_VOICES-1:0]                busy, start, lvl_bits, idle_oh, steal_oh;
   logic [NUM_VOICES-1:0][1:0]           v_prio;
   logic [NUM_VOICES-1:0][DIV_WIDTH-1:0] v_pitch;
   logic [1:0]    best_prio;
   logic          drop_nxt, valid_trig;
   logic [AW-1:0] level_nxt;
   logic [SW-1:0] acc, sd_sum;

   assign frame_tick = vsync & ~prev_vsync;
   assign tone_tick  = pwm_base & ~prev_pwm_base;
   assign valid_trig = trig & (trig_mode != 2'd0);
   assign voice_busy = busy;

   // edge detectors start high so inputs held high through reset give no tick
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_vsync    <= 1'b1;
         prev_pwm_base <= 1'b1;
      end else begin
         prev_vsync    <= vsync;
         prev_pwm_base <= pwm_base;
      end
   end

   // allocation from registered state: first idle voice, else weakest lower-priority voice
   always_comb begin
      idle_oh   = '0;
      steal_oh  = '0;
      best_prio = 2'd0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!busy[i] && (idle_oh == '0)) idle_oh[i] = 1'b1;
         if (busy[i] && (v_prio[i] < trig_prio) &&
             ((steal_oh == '0) || (v_prio[i] < best_prio))) begin
            steal_oh    = '0;
            steal_oh[i] = 1'b1;
            best_prio   = v_prio[i];
         end
      end
      start    = '0;
      drop_nxt = 1'b0;
      if (valid_trig) begin
         if (idle_oh != '0)       start = idle_oh;
         else if (steal_oh != '0) start = steal_oh;
         else                     drop_nxt = 1'b1;
      end
   end

   generate
      for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
         sound_voice #(.DIV_WIDTH(DIV_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_voice (
            .clk         (clk),
            .rst         (rst),
            .start       (start[i]),
            .frame_tick  (frame_tick),
            .tone_tick   (tone_tick),
            .start_mode  (trig_mode),
            .start_pitch (trig_pitch),
            .start_len   (trig_len),
            .start_prio  (trig_prio),
            .busy        (busy[i]),
            .prio        (v_prio[i]),
            .pitch       (v_pitch[i]),
            .level_bit   (lvl_bits[i])
         );
      end
   endgenerate

   // popcount of audible voices
   always_comb begin
      level_nxt = '0;
      for (int i = 0; i < NUM_VOICES; i++) level_nxt = level_nxt + AW'(lvl_bits[i]);
   end

   assign sd_sum = acc + SW'(audio_level);

   // level register, drop pulse and first-order sigma-delta
   always_ff @(posedge clk) begin
      if (rst) begin
         audio_level <= '0;
         trig_drop   <= 1'b0;
         acc         <= '0;
         audio       <= 1'b0;
      end else begin
         audio_level <= level_nxt;
         trig_drop   <= drop_nxt;
         if (sd_sum >= SW'(NUM_VOICES)) begin
            audio <= 1'b1;
            acc   <= sd_sum - SW'(NUM_VOICES);
         end else begin
            audio <= 1'b0;
            acc   <= sd_sum;
         end
      end
   end
endmodule

// File: tb/tb_sound_voices.sv
// Directed bench for sound_voices with NUM_VOICES=2, DIV_WIDTH=4, LEN_WIDTH=5.

module tb_sound_voices;
   logic       clk, rst, vsync, pwm_base, trig;
   logic [1:0] trig_mode, trig_prio;
   logic [3:0] trig_pitch;
   logic [4:0] trig_len;
   logic [1:0] voice_busy;
   logic       trig_drop;
   logic [1:0] audio_level;
   logic       audio;

   int n_chk = 0;
   int n_fail = 0;

   sound_voices #(.NUM_VOICES(2), .DIV_WIDTH(4), .LEN_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .vsync(vsync), .pwm_base(pwm_base), .trig(trig),
      .trig_mode(trig_mode), .trig_pitch(trig_pitch), .trig_len(trig_len),
      .trig_prio(trig_prio), .voice_busy(voice_busy), .trig_drop(trig_drop),
      .audio_level(audio_level), .audio(audio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      logic [1:0] prio;
      logic [1:0] exp_busy;
      logic       exp_drop;
      logic [1:0] exp_p0;
      logic [1:0] exp_p1;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic set_trig(input logic [1:0] m, input logic [3:0] p,
                           input logic [4:0] l, input logic [1:0] pr);
      trig = 1'b1; trig_mode = m; trig_pitch = p; trig_len = l; trig_prio = pr;
   endtask

   task automatic do_trig(input logic [1:0] m, input logic [3:0] p,
                          input logic [4:0] l, input logic [1:0] pr);
      set_trig(m, p, l, pr);
      tick();
      trig = 1'b0;
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
   endtask

   task automatic pulse_pwm();
      pwm_base = 1'b1; tick();
      pwm_base = 1'b0; tick();
   endtask

   initial begin
      logic [3:0] sweep_exp [8];
      logic       sq;
      sweep_exp = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11};

      //             mode  prio  busy   drop  p0     p1
      tbl[0] = '{2'd1, 2'd1, 2'b01, 1'b0, 2'd1, 2'd0};
      tbl[1] = '{2'd1, 2'd1, 2'b11, 1'b0, 2'd1, 2'd1};
      tbl[2] = '{2'd1, 2'd2, 2'b11, 1'b0, 2'd2, 2'd1};
      tbl[3] = '{2'd1, 2'd0, 2'b11, 1'b1, 2'd2, 2'd1};
      tbl[4] = '{2'd0, 2'd3, 2'b11, 1'b0, 2'd2, 2'd1};
      tbl[5] = '{2'd1, 2'd1, 2'b11, 1'b1, 2'd2, 2'd1};
      tbl[6] = '{2'd1, 2'd3, 2'b11, 1'b0, 2'd2, 2'd3};
      tbl[7] = '{2'd1, 2'd3, 2'b11, 1'b0, 2'd3, 2'd3};
      tbl[8] = '{2'd1, 2'd3, 2'b11, 1'b1, 2'd3, 2'd3};

      trig = 1'b0; trig_mode = '0; trig_pitch = '0; trig_len = '0; trig_prio = '0;

      // 1: inputs high across reset release give no tick
      vsync = 1'b1; pwm_base = 1'b1;
      do_reset();
      tick(); tick();
      chk("rst_busy", voice_busy, 0);
      chk("rst_level", audio_level, 0);
      chk("rst_audio", audio, 0);
      chk("rst_drop", trig_drop, 0);
      chk("rst_prev_vsync", dut.prev_vsync, 1);
      chk("rst_prev_pwm", dut.prev_pwm_base, 1);
      vsync = 1'b0; pwm_base = 1'b0;
      tick();

      // 2: BLIP pitch 3 len 4, tone tick every 4 clk
      do_reset();
      do_trig(2'd1, 4'd3, 5'd4, 2'd1);
      chk("blip_busy", voice_busy, 1);
      for (int k = 0; k < 10; k++) begin
         pwm_base = 1'b1; tick(); tick();
         pwm_base = 1'b0; tick(); tick();
         chk($sformatf("blip_sq_%0d", k), audio_level, ((k + 1) / 4) % 2);
      end
      for (int f = 0; f < 4; f++) begin
         pulse_vsync();
         chk($sformatf("blip_frame_%0d", f), voice_busy, (f < 3) ? 1 : 0);
      end
      chk("blip_idle_level", audio_level, 0);

      // 3: allocation / stealing / drop table
      do_reset();
      for (int i = 0; i < 9; i++) begin
         do_trig(tbl[i].mode, 4'd5, 5'd20, tbl[i].prio);
         chk($sformatf("alloc_busy_%0d", i), voice_busy, tbl[i].exp_busy);
         chk($sformatf("alloc_drop_%0d", i), trig_drop, tbl[i].exp_drop);
         chk($sformatf("alloc_p0_%0d", i), dut.v_prio[0], tbl[i].exp_p0);
         chk($sformatf("alloc_p1_%0d", i), dut.v_prio[1], tbl[i].exp_p1);
         tick();
         chk($sformatf("alloc_drop_clr_%0d", i), trig_drop, 0);
      end

      // ending voice still counts as busy for a same-cycle trig
      do_reset();
      do_trig(2'd1, 4'd0, 5'd1, 2'd3);
      do_trig(2'd1, 4'd0, 5'd5, 2'd3);
      vsync = 1'b1;
      set_trig(2'd1, 4'd0, 5'd5, 2'd0);
      tick();
      trig = 1'b0; vsync = 1'b0;
      chk("end_vs_trig_busy", voice_busy, 2'b10);
      chk("end_vs_trig_drop", trig_drop, 1);
      tick();
      // start on a frame-tick cycle ignores that tick
      vsync = 1'b1;
      set_trig(2'd1, 4'd0, 5'd1, 2'd2);
      tick();
      trig = 1'b0; vsync = 1'b0;
      chk("start_on_frame", voice_busy, 2'b11);
      tick();
      pulse_vsync();
      chk("start_on_frame_end", voice_busy, 2'b10);
      // len 0 behaves as len 1
      do_trig(2'd1, 4'd0, 5'd0, 2'd2);
      chk("len0_busy", voice_busy, 2'b11);
      pulse_vsync();
      chk("len0_end", voice_busy, 2'b10);

      // 4: SWEEP saturating high, then descending
      do_reset();
      do_trig(2'd2, 4'd14, 5'd8, 2'd1);
      for (int f = 0; f < 8; f++) begin
         pulse_vsync();
         chk($sformatf("sweep_pitch_%0d", f), dut.v_pitch[0], sweep_exp[f]);
         chk($sformatf("sweep_busy_%0d", f), voice_busy, (f < 7) ? 1 : 0);
      end
      // SWEEP saturating low: 0 -> 1 -> 0 -> 0
      do_reset();
      do_trig(2'd2, 4'd0, 5'd3, 2'd1);
      pulse_vsync(); chk("sweep_lo_0", dut.v_pitch[0], 1);
      pulse_vsync(); chk("sweep_lo_1", dut.v_pitch[0], 0);
      pulse_vsync(); chk("sweep_lo_2", dut.v_pitch[0], 0);
      chk("sweep_lo_idle", voice_busy, 0);

      // 5: WARBLE masks frames 4-7 while the tone keeps running
      do_reset();
      do_trig(2'd3, 4'd0, 5'd12, 2'd1);
      sq = 1'b0;
      for (int f = 0; f < 12; f++) begin
         pulse_pwm();
         sq = ~sq;
         chk($sformatf("warble_lvl_%0d", f), audio_level,
             (sq && !(f >= 4 && f <= 7)) ? 1 : 0);
         pulse_vsync();
      end
      chk("warble_idle", voice_busy, 0);

      // 6: sigma-delta, both voices high -> constant 1
      do_reset();
      do_trig(2'd1, 4'd0, 5'd30, 2'd1);
      do_trig(2'd1, 4'd0, 5'd30, 2'd1);
      pulse_pwm();
      chk("sd_both_level", audio_level, 2);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("sd_both_%0d", k), audio, 1);
      end
      // reset mid-sound silences on the next edge
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_busy", voice_busy, 0);
      chk("midrst_audio", audio, 0);
      chk("midrst_level", audio_level, 0);
      tick();
      // one voice high -> audio alternates
      do_trig(2'd1, 4'd0, 5'd30, 2'd1);
      pulse_pwm();
      chk("sd_one_level", audio_level, 1);
      chk("sd_one_init", audio, 0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("sd_one_%0d", k), audio, (k % 2 == 0) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
